stage_f_prefetch: RTL and testbench
===================================

// Module: stage_f_prefetch
// PURPOSE
//  Parametrised Polaris instruction fetch stage: drives the 32-bit F-bus (classic Wishbone, one
//  cycle outstanding) and queues fetched words in a DEPTH-entry prefetch FIFO toward decode.
//  Adds redirect (branch/trap) with flush, decode backpressure, and optional bus-error tagging.
//  Sits between the F-bus interconnect and the decode stage.
// PARAMETERS
//  ADDR_W    64                      byte-address width; word address is [ADDR_W-1:2]
//  DEPTH     4                       FIFO entries; power of two, >=2
//  RESET_PC  64'hFFFF_FFFF_FFFF_FF00 byte address of first fetch; bits [1:0] ignored
// PORTS
//  clk_i          in   1         clock, all state on rising edge
//  reset_ni       in   1         asynchronous, active-low reset
//  f_cyc_o        out  1         bus cycle active; implies f_stb_o, f_sel=4'hF
//  f_stb_o        out  1         strobe; always equals f_cyc_o
//  f_adr_o        out  ADDR_W-2  word address, [ADDR_W-1:2]; this is the fetch PC
//  f_ack_i        in   1         bus ack; may be combinational in the cycle f_cyc_o is high
//  f_dat_i        in   32        instruction word, valid with f_ack_i
//  f_err_i        in   1         bus error (only with F_ERR_EN)
//  redirect_i     in   1         one-cycle pulse: flush and refetch from redirect_pc_i
//  redirect_pc_i  in   ADDR_W-2  new word address
//  i_valid_o      out  1         FIFO head valid
//  i_ready_i      in   1         decode accepts head (pop when i_valid_o & i_ready_i)
//  i_pc_o         out  ADDR_W-2  word address of head instruction
//  i_insn_o       out  32        head instruction
//  i_err_o        out  1         head fetch faulted (0 without F_ERR_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): f_cyc_o=f_stb_o=0, f_adr_o=RESET_PC[ADDR_W-1:2],
//    FIFO count=0, i_valid_o=0, i_pc_o/i_insn_o=0, state=IDLE. f_cyc_o rises 1st clk after release.
//  - FSM states IDLE, FETCH, HALT (HALT only with F_ERR_EN).
//    IDLE->FETCH when count<DEPTH (count as it will be after this edge's push/pop).
//    FETCH: f_cyc_o=1, f_adr_o stable until ack. On f_cyc_o&f_ack_i: push {f_adr_o,f_dat_i,0},
//    f_adr_o<=f_adr_o+1 (wraps mod 2^(ADDR_W-2)); stay FETCH if post-edge count<DEPTH, else IDLE.
//    Ack present in every cycle -> one word per clock (zero-wait memory).
//  - No ack: no push, address held, bubble only; never drops the cycle except on redirect/reset.
//  - Ack while f_cyc_o=0 is ignored.
//  - Full: no request issued; simultaneous pop and push leaves count unchanged; no overflow.
//  - Pop on empty is ignored. i_* reflect head combinationally from FIFO storage.
//  - redirect_i: at that edge FIFO flushed (count=0, pointers reset), f_adr_o<=redirect_pc_i,
//    f_cyc_o<=0 for exactly one cycle (aborts open cycle), state->IDLE; an ack or pop in the
//    same cycle is discarded. Fetch resumes at redirect_pc_i the next cycle.
//    i_valid_o=0 the cycle after redirect. Redirect has priority over every other event,
//    except reset.
//  - Reset mid-cycle: f_cyc_o drops asynchronously; no push.
// CONFIGURATION
//  F_ERR_EN defined: f_err_i port exists; f_cyc_o&f_err_i pushes {f_adr_o,32'h0,1}, f_adr_o
//    holds, state->HALT (f_cyc_o=0) until redirect_i. err and ack together: err wins.
//  F_ERR_EN undefined: no f_err_i port, i_err_o tied 0, no HALT state.
// TESTING
//  1 reset release, ack tied 1, i_ready_i=1 -> adr 3FFF..FFC0,C1,C2...; one insn/clk, pc matches.
//  2 i_ready_i=0, ack=1, DEPTH=4 -> exactly 4 pushes, f_cyc_o=0, adr=RESET+4; ready=1 resumes.
//  3 ack every 3rd cycle -> f_adr_o held 2 cycles, no duplicate or lost words, order preserved.
//  4 redirect_i to 0x100 (word 0x40) with ack same cycle -> that word dropped, FIFO empty,
//    f_cyc_o low 1 clk, next fetch adr 0x40.
//  5 F_ERR_EN: f_err_i at adr 0x40 -> head i_err_o=1 i_pc_o=0x40, f_cyc_o=0 until redirect.
//  6 f_adr_o=all-ones, ack -> wraps to 0; reset asserted mid-fetch -> outputs at reset values.

Source files
------------

// File: rtl/stage_f_prefetch.sv
// -----------------------------------------------------------------------------
// stage_f_prefetch
//
// Instruction fetch stage for the Polaris core. Masters the 32-bit F-bus
// (classic Wishbone, single outstanding cycle) and buffers fetched words in a
// DEPTH-entry prefetch FIFO that feeds the decode stage. A redirect pulse
// (branch/trap) flushes the FIFO and restarts fetching at a new word address.
//
// Optional feature macro: F_ERR_EN
//   defined   : f_err_i port exists; a bus error pushes a tagged entry
//               {pc, 32'h0, err=1} and parks the fetcher in HALT until redirect.
//   undefined : no f_err_i port, i_err_o tied low, no HALT state.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   reset_ni       asynchronous active-low reset (release is synchronous)
//   f_cyc_o        bus cycle active (select is implicitly 4'hF)
//   f_stb_o        strobe, always equal to f_cyc_o
//   f_adr_o        word address [ADDR_W-1:2]; this is the fetch PC
//   f_ack_i        bus acknowledge, may be combinational with f_cyc_o
//   f_dat_i        instruction word, valid with f_ack_i
//   f_err_i        bus error (F_ERR_EN builds only)
//   redirect_i     one-cycle pulse: flush and refetch from redirect_pc_i
//   redirect_pc_i  new fetch word address
//   i_valid_o      FIFO head valid
//   i_ready_i      decode accepts head (pop on i_valid_o & i_ready_i)
//   i_pc_o         word address of head instruction (0 when empty)
//   i_insn_o       head instruction (0 when empty)
//   i_err_o        head fetch faulted
// -----------------------------------------------------------------------------
module stage_f_prefetch #(
   parameter int          ADDR_W   = 64,
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   output logic              f_cyc_o,
   output logic              f_stb_o,
   output logic [ADDR_W-3:0] f_adr_o,
   input  logic              f_ack_i,
   input  logic [31:0]       f_dat_i,
`ifdef F_ERR_EN
   input  logic              f_err_i,
`endif
   input  logic              redirect_i,
   input  logic [ADDR_W-3:0] redirect_pc_i,
   output logic              i_valid_o,
   input  logic              i_ready_i,
   output logic [ADDR_W-3:0] i_pc_o,
   output logic [31:0]       i_insn_o,
   output logic              i_err_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_W - 2;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [WA_W-1:0]  RESET_WA = RESET_PC[ADDR_W-1:2];

`ifdef F_ERR_EN
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HALT} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_FETCH} state_t;
`endif

   state_t            state_q, state_d;
   logic              cyc_q, cyc_d;
   logic [WA_W-1:0]   adr_q, adr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // FIFO storage: plain arrays, no reset; head is gated by valid instead.
   logic [WA_W-1:0]   pc_mem   [DEPTH];
   logic [31:0]       insn_mem [DEPTH];
`ifdef F_ERR_EN
   logic              err_mem  [DEPTH];
`endif

   logic              bus_err;
   logic              push;
   logic              push_ok;
   logic              pop;
   logic              mem_we;
   logic [CNT_W-1:0]  count_after;

   always_comb begin
`ifdef F_ERR_EN
      bus_err = cyc_q & f_err_i;
`else
      bus_err = 1'b0;
`endif
      // Error wins over ack; both produce a FIFO entry.
      push_ok = cyc_q & f_ack_i & ~bus_err;
      push    = push_ok | bus_err;
      pop     = (count_q != '0) & i_ready_i;
      mem_we  = push & ~redirect_i;

      count_after = count_q;
      if (push && !pop) begin
         count_after = count_q + 1'b1;
      end else if (pop && !push) begin
         count_after = count_q - 1'b1;
      end

      state_d  = state_q;
      cyc_d    = cyc_q;
      adr_d    = adr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (redirect_i) begin
         // Redirect beats everything: discard this cycle's ack and pop,
         // abort the open bus cycle and idle for exactly one clock.
         state_d  = ST_IDLE;
         cyc_d    = 1'b0;
         adr_d    = redirect_pc_i;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_after;

         case (state_q)
            ST_IDLE: begin
               if (count_after < DEPTH_C) begin
                  state_d = ST_FETCH;
                  cyc_d   = 1'b1;
               end
            end
            ST_FETCH: begin
               if (bus_err) begin
`ifdef F_ERR_EN
                  // Faulting address is kept so a debugger sees it on f_adr_o.
                  state_d = ST_HALT;
                  cyc_d   = 1'b0;
`endif
               end else if (push_ok) begin
                  adr_d = adr_q + 1'b1;
                  if (count_after >= DEPTH_C) begin
                     state_d = ST_IDLE;
                     cyc_d   = 1'b0;
                  end
               end
            end
`ifdef F_ERR_EN
            ST_HALT: begin
               cyc_d = 1'b0;
            end
`endif
            default: begin
               state_d = ST_IDLE;
               cyc_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= ST_IDLE;
         cyc_q    <= 1'b0;
         adr_q    <= RESET_WA;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         adr_q    <= adr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         pc_mem[wr_ptr_q]   <= adr_q;
         insn_mem[wr_ptr_q] <= bus_err ? 32'h0 : f_dat_i;
`ifdef F_ERR_EN
         err_mem[wr_ptr_q]  <= bus_err;
`endif
      end
   end

   assign f_cyc_o   = cyc_q;
   assign f_stb_o   = cyc_q;
   assign f_adr_o   = adr_q;
   assign i_valid_o = (count_q != '0);
   assign i_pc_o    = i_valid_o ? pc_mem[rd_ptr_q]   : '0;
   assign i_insn_o  = i_valid_o ? insn_mem[rd_ptr_q] : 32'h0;
`ifdef F_ERR_EN
   assign i_err_o   = i_valid_o & err_mem[rd_ptr_q];
`else
   assign i_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_stage_f_prefetch.sv
module tb_stage_f_prefetch;

   localparam logic [61:0] RST_WA = 62'h3FFF_FFFF_FFFF_FFC0;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        f_cyc_o, f_stb_o;
   logic [61:0] f_adr_o;
   logic        f_ack_i;
   logic [31:0] f_dat_i;
   logic        f_err_i;
   logic        redirect_i;
   logic [61:0] redirect_pc_i;
   logic        i_valid_o, i_ready_i;
   logic [61:0] i_pc_o;
   logic [31:0] i_insn_o;
   logic        i_err_o;

   always #5 clk_i = ~clk_i;

   stage_f_prefetch dut (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .f_cyc_o       (f_cyc_o),
      .f_stb_o       (f_stb_o),
      .f_adr_o       (f_adr_o),
      .f_ack_i       (f_ack_i),
      .f_dat_i       (f_dat_i),
`ifdef F_ERR_EN
      .f_err_i       (f_err_i),
`endif
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .i_valid_o     (i_valid_o),
      .i_ready_i     (i_ready_i),
      .i_pc_o        (i_pc_o),
      .i_insn_o      (i_insn_o),
      .i_err_o       (i_err_o)
   );

   // Memory contents: a fixed pattern of the word address.
   function automatic logic [31:0] mem_word(input logic [61:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   assign f_dat_i = mem_word(f_adr_o);

   typedef struct packed {
      logic [61:0] pc;
      logic [31:0] insn;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [61:0] exp_adr;
   int          push_cnt;
   int          checks;
   int          failures;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Bus side: every accepted beat must be at the expected address; record
   // what decode should later see.
   always @(negedge clk_i) begin
      logic e;
      exp_t x;
      if (reset_ni) begin
`ifdef F_ERR_EN
         e = f_err_i;
`else
         e = 1'b0;
`endif
         if (redirect_i) begin
            exp_q.delete();
            exp_adr = redirect_pc_i;
         end else if (f_cyc_o && (f_ack_i || e)) begin
            chk("fetch_adr", {2'b00, f_adr_o}, {2'b00, exp_adr});
            x.pc   = exp_adr;
            x.insn = e ? 32'h0 : mem_word(exp_adr);
            x.err  = e;
            exp_q.push_back(x);
            if (!e) exp_adr = exp_adr + 1'b1;
            push_cnt++;
            $display("push pc=%0h err=%0b", x.pc, x.err);
         end
      end
   end

   // Decode side monitor: pop and compare on each accepted head.
   always @(negedge clk_i) begin
      exp_t x;
      if (reset_ni && !redirect_i && i_valid_o && i_ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=pc%0h required=none", i_pc_o);
         end else begin
            x = exp_q.pop_front();
            chk("pop_pc", {2'b00, i_pc_o}, {2'b00, x.pc});
            chk("pop_insn", {32'h0, i_insn_o}, {32'h0, x.insn});
            chk("pop_err", {63'h0, i_err_o}, {63'h0, x.err});
            $display("pop  pc=%0h insn=%08h err=%0b", i_pc_o, i_insn_o, i_err_o);
         end
      end
   end

   task automatic step(input logic a, input logic r, input logic d);
      f_ack_i    = a;
      i_ready_i  = r;
      redirect_i = d;
      @(posedge clk_i);
      #1;
      redirect_i = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cyc"},  {63'h0, f_cyc_o}, 64'h0);
      chk({tag, "_stb"},  {63'h0, f_stb_o}, 64'h0);
      chk({tag, "_adr"},  {2'b00, f_adr_o}, {2'b00, RST_WA});
      chk({tag, "_valid"}, {63'h0, i_valid_o}, 64'h0);
      chk({tag, "_pc"},   {2'b00, i_pc_o}, 64'h0);
      chk({tag, "_insn"}, {32'h0, i_insn_o}, 64'h0);
   endtask

   logic [61:0] base;
   int          pc0;

   initial begin
      checks = 0; failures = 0; push_cnt = 0;
      f_ack_i = 0; i_ready_i = 0; redirect_i = 0; redirect_pc_i = '0; f_err_i = 0;
      exp_adr = RST_WA;
      reset_ni = 1'b1;
      #2 reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_state("reset");
      reset_ni = 1'b1;

      // 1: streaming from reset PC, one word per clock
      step(1, 1, 0);
      chk("t1_cyc_rise", {63'h0, f_cyc_o}, 64'h1);
      chk("t1_adr0", {2'b00, f_adr_o}, {2'b00, RST_WA});
      repeat (10) step(1, 1, 0);
      chk("t1_adr_adv", {2'b00, f_adr_o}, {2'b00, RST_WA + 62'd10});
      repeat (3) step(0, 1, 0);
      chk("t1_empty", {63'h0, i_valid_o}, 64'h0);
      chk("t1_cyc_held", {63'h0, f_cyc_o}, 64'h1);

      // 2: decode stalled -> fill exactly DEPTH then stop requesting
      base = exp_adr;
      pc0  = push_cnt;
      repeat (8) step(1, 0, 0);
      chk("t2_pushes", 64'(push_cnt - pc0), 64'd4);
      chk("t2_cyc_off", {63'h0, f_cyc_o}, 64'h0);
      chk("t2_adr", {2'b00, f_adr_o}, {2'b00, base + 62'd4});
      chk("t2_valid", {63'h0, i_valid_o}, 64'h1);
      chk("t2_head_pc", {2'b00, i_pc_o}, {2'b00, base});
      repeat (8) step(1, 1, 0);

      // 3: ack every third cycle, address must hold between acks
      for (int i = 0; i < 15; i++) begin
         step((i % 3) == 2, 1, 0);
         chk("t3_adr", {2'b00, f_adr_o}, {2'b00, exp_adr});
      end
      repeat (3) step(0, 1, 0);

      // 4: redirect with a same-cycle ack
      repeat (2) step(1, 0, 0);
      redirect_pc_i = 62'h40;
      step(1, 0, 1);
      chk("t4_cyc_low", {63'h0, f_cyc_o}, 64'h0);
      chk("t4_flushed", {63'h0, i_valid_o}, 64'h0);
      chk("t4_adr", {2'b00, f_adr_o}, 64'h40);
      step(0, 1, 0);
      chk("t4_cyc_back", {63'h0, f_cyc_o}, 64'h1);
      chk("t4_adr_next", {2'b00, f_adr_o}, 64'h40);
      repeat (4) step(1, 1, 0);
      chk("t4_adr_run", {2'b00, f_adr_o}, 64'h44);

`ifdef F_ERR_EN
      // 5: bus error tags the entry and parks the fetcher
      redirect_pc_i = 62'h40;
      step(0, 0, 1);
      step(0, 0, 0);
      f_err_i = 1'b1;
      step(1, 0, 0);
      f_err_i = 1'b0;
      chk("t5_cyc_off", {63'h0, f_cyc_o}, 64'h0);
      repeat (3) step(1, 0, 0);
      chk("t5_halted", {63'h0, f_cyc_o}, 64'h0);
      chk("t5_adr", {2'b00, f_adr_o}, 64'h40);
      chk("t5_err", {63'h0, i_err_o}, 64'h1);
      chk("t5_pc", {2'b00, i_pc_o}, 64'h40);
      step(0, 1, 0);
      chk("t5_popped", {63'h0, i_valid_o}, 64'h0);
`endif

      // 6: address wrap, then reset in the middle of a bus cycle
      redirect_pc_i = '1;
      step(0, 1, 1);
      step(0, 1, 0);
      chk("t6_adr_ones", {2'b00, f_adr_o}, 64'h3FFF_FFFF_FFFF_FFFF);
      step(1, 1, 0);
      chk("t6_wrap", {2'b00, f_adr_o}, 64'h0);
      repeat (3) step(1, 1, 0);
      f_ack_i = 1'b0;
      chk("t6_cyc_before", {63'h0, f_cyc_o}, 64'h1);
      #3 reset_ni = 1'b0;
      #1;
      chk_reset_state("midreset");
      exp_q.delete();
      exp_adr = RST_WA;
      @(posedge clk_i);
      #1 reset_ni = 1'b1;
      repeat (6) step(1, 1, 0);
      repeat (3) step(0, 1, 0);
      chk("sb_drained", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
